// File: rtl/ramped_ask_modulator.sv
// On-off keyed amplitude source: one bit per symbol selects highlevel or lowlevel,
// and the output level slews toward that target by at most ramp_step per sample.
module ramped_ask_modulator #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             tx_tdata,
    input  logic             tx_tvalid,
    output logic             tx_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    input  logic [WIDTH-1:0] highlevel,
    input  logic [WIDTH-1:0] lowlevel,
    input  logic [WIDTH-1:0] ramp_step,
    input  logic [CNTW-1:0]  samples_per_symbol,
    output logic             underrun,
    output logic             tx_active
);

    logic [WIDTH-1:0] level_q, level_d;
    logic             cur_bit_q, cur_bit_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             tx_active_q, tx_active_d;
    logic             underrun_q, underrun_d;

    logic [CNTW-1:0]     sps_eff;
    logic                boundary;
    logic                xfer;
    logic [WIDTH-1:0]    target;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]      mag;

    always_comb begin
        sps_eff     = (samples_per_symbol == '0) ? CNTW'(1) : samples_per_symbol;
        // >= rather than == so shrinking samples_per_symbol mid-symbol still terminates it
        boundary    = (cnt_q >= (sps_eff - CNTW'(1)));
        xfer        = enable & o_tready;

        cnt_d       = cnt_q;
        cur_bit_d   = cur_bit_q;
        tx_active_d = tx_active_q;
        underrun_d  = 1'b0;
        level_d     = level_q;

        if (xfer) begin
            if (boundary) begin
                cnt_d = '0;
                if (tx_tvalid) begin
                    cur_bit_d   = tx_tdata;
                    tx_active_d = 1'b1;
                end else begin
                    cur_bit_d   = 1'b1;
                    tx_active_d = 1'b0;
                    underrun_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end

        // Target follows the bit being written this transfer, so a new symbol ramps immediately
        target = cur_bit_d ? lowlevel : highlevel;
        diff   = $signed({target[WIDTH-1], target}) - $signed({level_q[WIDTH-1], level_q});
        mag    = diff[WIDTH] ? (~diff + 1'b1) : diff;

        if (xfer) begin
            if ((ramp_step == '0) || (mag <= {1'b0, ramp_step})) begin
                level_d = target;
            end else if (!diff[WIDTH]) begin
                // Partial step lands strictly between level and target, so modular add cannot wrap
                level_d = level_q + ramp_step;
            end else begin
                level_d = level_q - ramp_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            level_q     <= '0;
            cur_bit_q   <= 1'b1;
            cnt_q       <= '0;
            tx_active_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            level_q     <= level_d;
            cur_bit_q   <= cur_bit_d;
            cnt_q       <= cnt_d;
            tx_active_q <= tx_active_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_tdata   = level_q;
    assign o_tvalid  = enable;
    assign tx_tready = enable & o_tready & boundary;
    assign underrun  = underrun_q & enable;
    assign tx_active = tx_active_q;

endmodule

// File: tb/tb_ramped_ask_modulator.sv
// Bench for ramped_ask_modulator: per-cycle comparison against a symbol-level model,
// directed sequences with literal expectations, then randomized traffic.
module tb_ramped_ask_modulator;
    localparam int WIDTH = 16;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             reset, clear, enable, tx_tdata, tx_tvalid, tx_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid, o_tready;
    logic [WIDTH-1:0] highlevel, lowlevel, ramp_step;
    logic [CNTW-1:0]  samples_per_symbol;
    logic             underrun, tx_active;

    ramped_ask_modulator #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .highlevel(highlevel), .lowlevel(lowlevel), .ramp_step(ramp_step),
        .samples_per_symbol(samples_per_symbol),
        .underrun(underrun), .tx_active(tx_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit txq[$];

    // Model: position in symbol, current symbol's bit, and the slewed level.
    int m_level = 0, m_pos = 0, m_bit = 1, m_act = 0, m_under = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sps_now();
        return (samples_per_symbol == 0) ? 1 : int'(samples_per_symbol);
    endfunction

    always @(posedge clk) begin
        if (reset || clear) begin
            m_level = 0; m_pos = 0; m_bit = 1; m_act = 0; m_under = 0;
        end else if (enable && o_tready) begin
            int tgt, d, st;
            if (m_pos >= sps_now() - 1) begin
                m_pos = 0;
                if (tx_tvalid) begin
                    m_bit = int'(tx_tdata); m_act = 1; m_under = 0;
                    if (txq.size() > 0) void'(txq.pop_front());
                end else begin
                    m_bit = 1; m_act = 0; m_under = 1;
                end
            end else begin
                m_pos++; m_under = 0;
            end
            tgt = (m_bit == 1) ? int'($signed(lowlevel)) : int'($signed(highlevel));
            d   = tgt - m_level;
            st  = int'(ramp_step);
            if (st == 0 || (d < 0 ? -d : d) <= st) m_level = tgt;
            else m_level = m_level + ((d > 0) ? st : -st);
        end else begin
            m_under = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_tdata", int'($signed(o_tdata)), m_level);
            chk("o_tvalid", int'(o_tvalid), int'(enable));
            chk("tx_tready", int'(tx_tready),
                int'(enable && o_tready && (m_pos >= sps_now() - 1)));
            chk("underrun", int'(underrun), int'(m_under != 0 && enable));
            chk("tx_active", int'(tx_active), m_act);
        end
    end

    task automatic drive_tx(input bit gate);
        tx_tvalid = gate && (txq.size() > 0);
        tx_tdata  = (txq.size() > 0) ? txq[0] : 1'b1;
    endtask

    task automatic cyc(input bit gate);
        @(posedge clk); #1;
        drive_tx(gate);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1); cyc(1);
        reset = 1'b0;
    endtask

    task automatic setp(input int sps, input int st, input int lo, input int hi);
        samples_per_symbol = CNTW'(sps);
        ramp_step = WIDTH'(st);
        lowlevel  = WIDTH'(lo);
        highlevel = WIDTH'(hi);
    endtask

    int cap_d[13], cap_r[13], cap_u[13], cap_a[13];
    int ref_s[$], got_s[$];
    int exp_a[12] = '{0, -1000, -1000, -1000, 1000, 1000, 1000, 1000, -1000, -1000, -1000, -1000};
    int exp_b[12] = '{0, 0, 0, 0, 300, 600, 900, 1000, 700, 400, 100, 0};

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_d[i] = int'($signed(o_tdata));
            cap_r[i] = int'(tx_tready);
            cap_u[i] = int'(underrun);
            cap_a[i] = int'(tx_active);
            cyc(1);
        end
    endtask

    task automatic collect(input bit rnd, output int n);
        int guard;
        got_s.delete();
        guard = 0;
        while (got_s.size() < 40 && guard < 400) begin
            @(negedge clk);
            if (o_tvalid && o_tready) got_s.push_back(int'($signed(o_tdata)));
            cyc(1);
            o_tready = rnd ? ($urandom_range(1) == 1) : 1'b1;
            guard++;
        end
        n = got_s.size();
    endtask

    initial begin
        int n, hl, ll;
        reset = 1'b1; clear = 1'b0; enable = 1'b1; o_tready = 1'b1;
        tx_tvalid = 1'b0; tx_tdata = 1'b1;
        setp(4, 0, -1000, 1000);
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Instant switching, bits 0 then 1, then idle fill with underrun
        txq.delete(); txq.push_back(1'b0); txq.push_back(1'b1);
        do_reset(); drive_tx(1);
        capture(13);
        for (int i = 0; i < 12; i++) chk("seqA_data", cap_d[i], exp_a[i]);
        chk("seqA_ready3", cap_r[3], 1);
        chk("seqA_ready7", cap_r[7], 1);
        chk("seqA_ready5", cap_r[5], 0);
        chk("seqA_active", cap_a[4], 1);
        chk("seqA_underrun", cap_u[12], 1);
        chk("seqA_idle", cap_a[12], 0);

        // Ramped transitions
        setp(4, 300, 0, 1000);
        txq.delete(); txq.push_back(1'b0); txq.push_back(1'b1);
        do_reset(); drive_tx(1);
        capture(12);
        for (int i = 0; i < 12; i++) chk("seqB_data", cap_d[i], exp_b[i]);

        // Shrinking symbol length mid-symbol ends it on the next transfer
        setp(8, 0, -50, 50);
        txq.delete();
        do_reset(); drive_tx(1);
        for (int i = 0; i < 5; i++) cyc(1);
        samples_per_symbol = CNTW'(2);
        @(negedge clk);
        chk("sps_shrink_ready", int'(tx_tready), 1);

        // Reset in the middle of a high symbol
        setp(4, 0, -1000, 1000);
        txq.delete(); txq.push_back(1'b0);
        do_reset(); drive_tx(1);
        for (int i = 0; i < 6; i++) cyc(1);
        @(negedge clk);
        chk("mid_level", int'($signed(o_tdata)), 1000);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_level", int'($signed(o_tdata)), 0);
        chk("rst_ready", int'(tx_tready), 0);

        // Backpressure must not change the sample stream
        setp(3, 250, -500, 700);
        txq.delete();
        foreach (exp_b[i]) if (i < 8) txq.push_back(1'(($urandom_range(1))));
        ref_s.delete();
        begin
            bit saved[$];
            saved = txq;
            o_tready = 1'b1;
            do_reset(); drive_tx(1);
            collect(1'b0, n);
            ref_s = got_s;
            txq = saved;
            do_reset(); drive_tx(1);
            collect(1'b1, n);
        end
        chk("bp_count", n, ref_s.size());
        for (int i = 0; i < n && i < ref_s.size(); i++) chk("bp_sample", got_s[i], ref_s[i]);
        chk("bp_bits_left", txq.size(), 0);

        // Randomized traffic
        txq.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                samples_per_symbol = CNTW'(($urandom_range(5) == 5) ? 8 : $urandom_range(4));
                case ($urandom_range(3))
                    0: ramp_step = '0;
                    1: ramp_step = WIDTH'($urandom_range(1, 100));
                    2: ramp_step = WIDTH'($urandom_range(100, 5000));
                    default: ramp_step = 16'hFFFF;
                endcase
            end
            if (c % 40 == 0) begin
                hl = int'($urandom_range(40000)) - 20000;
                ll = int'($urandom_range(40000)) - 20000;
                highlevel = WIDTH'(hl);
                lowlevel  = WIDTH'(ll);
            end
            if (txq.size() < 3 && $urandom_range(2) != 0) txq.push_back(1'($urandom_range(1)));
            o_tready = ($urandom_range(3) != 0);
            enable   = ($urandom_range(15) != 0);
            reset    = ($urandom_range(499) == 0);
            clear    = ($urandom_range(299) == 0);
            drive_tx($urandom_range(4) != 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
